// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  // Arbitration policy selector; the MODE parameter carries the integer value.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int ARB_DEF_NUM_CH = 4;
  localparam int ARB_DEF_DATA_W = 8;

  // Width of a binary channel index. NUM_CH is at least 2, but the guard keeps
  // the width at 1 or more if someone instantiates a degenerate case.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant search: finds the first requester at or after ptr,
// wrapping modulo NUM_CH, and returns it as both one-hot and binary.
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int  NUM_CH = ARB_DEF_NUM_CH,
  parameter int  MODE   = 0,
  localparam int IW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx,
  output logic              any
);

  localparam logic [IW:0] LP_NCH = (IW+1)'(NUM_CH);

  logic [IW-1:0]       w_ptr;
  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [IW-1:0]       w_off;
  logic [IW:0]         w_sum;

  // Fixed priority is simply a search that always starts at channel 0.
  assign w_ptr = (MODE == int'(ARB_FIXED)) ? '0 : ptr;
  assign any   = |req;

  // Rotate the request vector so ptr lands at bit 0, take the lowest set bit,
  // then rotate the offset back to an absolute channel index.
  always_comb begin
    w_dbl = {req, req} >> w_ptr;
    w_rot = w_dbl[NUM_CH-1:0];
    w_off = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
    w_sum = {1'b0, w_off} + {1'b0, w_ptr};
    if (w_sum >= LP_NCH) w_sum = w_sum - LP_NCH;
    idx = w_sum[IW-1:0];
  end

  // Decode the winning index; all zero when nobody is requesting.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = any & (idx == IW'(i));
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel registered mux with round-robin or fixed-priority arbitration.
// One output register; refill-on-drain gives one beat per cycle.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int  NUM_CH = ARB_DEF_NUM_CH,
  parameter int  DATA_W = ARB_DEF_DATA_W,
  parameter int  MODE   = 0,
  localparam int IW     = idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IW-1:0]            out_sel,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        grant
);

  logic [IW-1:0]     r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [IW-1:0]     r_out_sel;

  logic [NUM_CH-1:0] w_grant;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_load_en;
  logic              w_in_xfer;
  logic [DATA_W-1:0] w_mux;
  logic [IW-1:0]     w_ptr_nxt;

  rr_grant #(
    .NUM_CH (NUM_CH),
    .MODE   (MODE)
  ) u_grant (
    .req   (in_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Register can take a beat when empty or being emptied this edge. rst_n
  // gates the accept so in_ready reads zero throughout reset.
  assign w_load_en = ~r_out_valid | out_ready;
  assign w_in_xfer = w_any & w_load_en & rst_n;
  assign in_ready  = w_grant & {NUM_CH{w_load_en & rst_n}};
  assign grant     = w_grant;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

  // Next pointer: one past the winner, wrapping from the top channel to 0.
  assign w_ptr_nxt = (w_idx == IW'(NUM_CH-1)) ? '0 : w_idx + IW'(1);

  // AND-OR mux: the grant is one-hot so at most one lane contributes.
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_mux = w_mux | (in_data[i*DATA_W +: DATA_W] & {DATA_W{w_grant[i]}});
    end
  end

  // Round-robin pointer; stays at 0 in fixed-priority mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_in_xfer && (MODE != int'(ARB_FIXED))) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Output register: load on input transfer, clear valid on a bare drain.
  // Data and sel hold after a drain so the last beat remains observable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
      r_out_sel   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: four instances cover round-robin,
// fixed priority, the 2:1 case and a wide 8-channel case.
module tb_rr_mux_arbiter;

  logic clk, rst_n;

  logic [3:0]   v0, rdy0, g0;
  logic [31:0]  d0;
  logic         ordy0, ov0;
  logic [7:0]   od0;
  logic [1:0]   os0;

  logic [3:0]   v1, rdy1, g1;
  logic [31:0]  d1;
  logic         ordy1, ov1;
  logic [7:0]   od1;
  logic [1:0]   os1;

  logic [1:0]   v2, rdy2, g2, d2;
  logic         ordy2, ov2, od2, os2;

  logic [7:0]   v3, rdy3, g3;
  logic [255:0] d3;
  logic         ordy3, ov3;
  logic [31:0]  od3;
  logic [2:0]   os3;

  int n_chk, n_pass;

  rr_mux_arbiter #(.NUM_CH(4), .DATA_W(8), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy0), .grant(g0));

  rr_mux_arbiter #(.NUM_CH(4), .DATA_W(8), .MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1), .grant(g1));

  rr_mux_arbiter #(.NUM_CH(2), .DATA_W(1), .MODE(0)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
    .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy2), .grant(g2));

  rr_mux_arbiter #(.NUM_CH(8), .DATA_W(32), .MODE(0)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3), .grant(g3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 4'b0101; d0 = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; ordy0 = 1'b0;
    #2;
    n_chk++; if (g0 !== 4'b0001) $display("FAIL reset_grant: got %b want %b", g0, 4'b0001); else n_pass++;
    n_chk++; if (rdy0 !== 4'b0000) $display("FAIL reset_ready: got %b want %b", rdy0, 4'b0000); else n_pass++;
    n_chk++; if (ov0 !== 1'b0 || od0 !== 8'h00 || os0 !== 2'd0)
      $display("FAIL reset_out: got v=%b d=%h s=%0d want v=0 d=00 s=0", ov0, od0, os0); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    v0 = 4'b0100;
    #1;
    n_chk++; if (g0 !== 4'b0100 || rdy0 !== 4'b0100)
      $display("FAIL first_grant: got g=%b r=%b want 0100/0100", g0, rdy0); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (ov0 !== 1'b1 || os0 !== 2'd2 || od0 !== 8'hD2)
      $display("FAIL first_beat: got v=%b s=%0d d=%h want 1/2/D2", ov0, os0, od0); else n_pass++;
    v0 = 4'b0000;
    #2; rst_n = 1'b0; #1;
    n_chk++; if (ov0 !== 1'b0 || od0 !== 8'h00 || os0 !== 2'd0)
      $display("FAIL midbeat_reset: got v=%b d=%h s=%0d want 0/00/0", ov0, od0, os0); else n_pass++;
    v0 = 4'b1111; #1;
    n_chk++; if (g0 !== 4'b0001 || rdy0 !== 4'b0000)
      $display("FAIL reset_ptr: got g=%b r=%b want 0001/0000", g0, rdy0); else n_pass++;
    v0 = 4'b0000;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_rr_fairness();
    d0 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; v0 = 4'b1111; ordy0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if (ov0 !== 1'b1 || os0 !== 2'(k % 4) || od0 !== 8'(8'hA0 + k % 4))
        $display("FAIL rr_seq[%0d]: got v=%b s=%0d d=%h want 1/%0d/%h", k, ov0, os0, od0, k % 4, 8'hA0 + k % 4);
      else n_pass++;
    end
    v0 = 4'b0000;
    @(posedge clk); #1;
    n_chk++; if (ov0 !== 1'b0) $display("FAIL rr_drain: got v=%b want 0", ov0); else n_pass++;
  endtask

  task automatic test_wrap();
    v0 = 4'b0100; #1;
    n_chk++; if (g0 !== 4'b0100) $display("FAIL wrap_g2: got %b want 0100", g0); else n_pass++;
    @(posedge clk); #1;
    v0 = 4'b0011; #1;
    n_chk++; if (g0 !== 4'b0001) $display("FAIL wrap_skip: got %b want 0001", g0); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (os0 !== 2'd0 || ov0 !== 1'b1) $display("FAIL wrap_sel0: got s=%0d v=%b want 0/1", os0, ov0); else n_pass++;
    n_chk++; if (g0 !== 4'b0010) $display("FAIL wrap_next: got %b want 0010", g0); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (os0 !== 2'd1) $display("FAIL wrap_sel1: got %0d want 1", os0); else n_pass++;
    v0 = 4'b1000; #1;
    n_chk++; if (g0 !== 4'b1000) $display("FAIL wrap_g3: got %b want 1000", g0); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (os0 !== 2'd3 || ov0 !== 1'b1) $display("FAIL wrap_sel3: got s=%0d v=%b want 3/1", os0, ov0); else n_pass++;
    v0 = 4'b1111; #1;
    n_chk++; if (g0 !== 4'b0001) $display("FAIL wrap_ptr0: got %b want 0001", g0); else n_pass++;
    v0 = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    ordy0 = 1'b0; d0 = {8'h13, 8'h12, 8'h55, 8'h10}; v0 = 4'b0010;
    @(posedge clk); #1;
    n_chk++; if (ov0 !== 1'b1 || os0 !== 2'd1 || od0 !== 8'h55)
      $display("FAIL bp_load: got v=%b s=%0d d=%h want 1/1/55", ov0, os0, od0); else n_pass++;
    v0 = 4'b1111; #1;
    n_chk++; if (g0 !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", g0); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (rdy0 !== 4'b0000 || ov0 !== 1'b1 || os0 !== 2'd1 || od0 !== 8'h55)
        $display("FAIL bp_stall[%0d]: got r=%b v=%b s=%0d d=%h want 0000/1/1/55", k, rdy0, ov0, os0, od0);
      else n_pass++;
      @(posedge clk); #1;
    end
    ordy0 = 1'b1; #1;
    n_chk++; if (rdy0 !== 4'b0100) $display("FAIL bp_release_ready: got %b want 0100", rdy0); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (ov0 !== 1'b1 || os0 !== 2'd2 || od0 !== 8'h12)
      $display("FAIL bp_refill: got v=%b s=%0d d=%h want 1/2/12", ov0, os0, od0); else n_pass++;
    v0 = 4'b0000;
    @(posedge clk); #1;
    n_chk++; if (ov0 !== 1'b0 || os0 !== 2'd2 || od0 !== 8'h12)
      $display("FAIL bp_hold_after_drain: got v=%b s=%0d d=%h want 0/2/12", ov0, os0, od0); else n_pass++;
  endtask

  task automatic test_fixed_priority();
    d1 = {8'h33, 8'h22, 8'h11, 8'h00}; v1 = 4'b1010; ordy1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if (g1 !== 4'b0010 || ov1 !== 1'b1 || os1 !== 2'd1 || od1 !== 8'h11)
        $display("FAIL fx_hold[%0d]: got g=%b v=%b s=%0d d=%h want 0010/1/1/11", k, g1, ov1, os1, od1);
      else n_pass++;
    end
    v1 = 4'b1000; #1;
    n_chk++; if (g1 !== 4'b1000) $display("FAIL fx_grant3: got %b want 1000", g1); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (ov1 !== 1'b1 || os1 !== 2'd3 || od1 !== 8'h33)
      $display("FAIL fx_beat3: got v=%b s=%0d d=%h want 1/3/33", ov1, os1, od1); else n_pass++;
    v1 = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_width_sweep();
    int p2, p3, gi2, gi3, bad2, bad3;
    logic m2_ov, m2_d, m2_s, x2, x3, m3_ov;
    logic [31:0] m3_d;
    logic [2:0]  m3_s;
    logic [1:0]  e2;
    logic [7:0]  e3;
    p2 = 0; p3 = 0; m2_ov = 1'b0; m2_d = 1'b0; m2_s = 1'b0;
    m3_ov = 1'b0; m3_d = '0; m3_s = '0;
    bad2 = 0; bad3 = 0;
    for (int c = 0; c < 200; c++) begin
      v2 = 2'($urandom); d2 = 2'($urandom); ordy2 = ($urandom_range(3, 0) != 0);
      v3 = 8'($urandom); ordy3 = ($urandom_range(3, 0) != 0);
      for (int ch = 0; ch < 8; ch++) d3[ch*32 +: 32] = $urandom;
      #1;
      gi2 = -1;
      for (int j = 0; j < 2; j++) if (gi2 < 0 && v2[(p2 + j) % 2]) gi2 = (p2 + j) % 2;
      gi3 = -1;
      for (int j = 0; j < 8; j++) if (gi3 < 0 && v3[(p3 + j) % 8]) gi3 = (p3 + j) % 8;
      x2 = (gi2 >= 0) && (!m2_ov || ordy2);
      x3 = (gi3 >= 0) && (!m3_ov || ordy3);
      e2 = (gi2 >= 0) ? 2'(1 << gi2) : 2'b00;
      e3 = (gi3 >= 0) ? 8'(1 << gi3) : 8'h00;
      n_chk++;
      if (g2 !== e2 || rdy2 !== (x2 ? e2 : 2'b00)) begin
        if (bad2 < 5) $display("FAIL n2_grant[%0d]: got g=%b r=%b want g=%b r=%b", c, g2, rdy2, e2, x2 ? e2 : 2'b00);
        bad2++;
      end else n_pass++;
      n_chk++;
      if (g3 !== e3 || rdy3 !== (x3 ? e3 : 8'h00)) begin
        if (bad3 < 5) $display("FAIL n8_grant[%0d]: got g=%b r=%b want g=%b r=%b", c, g3, rdy3, e3, x3 ? e3 : 8'h00);
        bad3++;
      end else n_pass++;
      @(posedge clk);
      if (x2) begin
        m2_ov = 1'b1; m2_d = d2[gi2]; m2_s = 1'(gi2); p2 = (gi2 + 1) % 2;
      end else if (ordy2) m2_ov = 1'b0;
      if (x3) begin
        m3_ov = 1'b1; m3_d = d3[gi3*32 +: 32]; m3_s = 3'(gi3); p3 = (gi3 + 1) % 8;
      end else if (ordy3) m3_ov = 1'b0;
      #1;
      n_chk++;
      if (ov2 !== m2_ov || od2 !== m2_d || os2 !== m2_s) begin
        if (bad2 < 5) $display("FAIL n2_out[%0d]: got v=%b d=%b s=%0d want v=%b d=%b s=%0d", c, ov2, od2, os2, m2_ov, m2_d, m2_s);
        bad2++;
      end else n_pass++;
      n_chk++;
      if (ov3 !== m3_ov || od3 !== m3_d || os3 !== m3_s) begin
        if (bad3 < 5) $display("FAIL n8_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c, ov3, od3, os3, m3_ov, m3_d, m3_s);
        bad3++;
      end else n_pass++;
    end
    v2 = '0; v3 = '0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    v0 = '0; d0 = '0; ordy0 = 1'b0;
    v1 = '0; d1 = '0; ordy1 = 1'b0;
    v2 = '0; d2 = '0; ordy2 = 1'b0;
    v3 = '0; d3 = '0; ordy3 = 1'b0;
    test_reset();
    test_rr_fairness();
    test_wrap();
    test_back_pressure();
    test_fixed_priority();
    test_width_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised N-channel registered multiplexer with built-in arbitration and valid/ready handshakes. It generalises the team's 2:1 mux and 2:4 decoder:
- The one-hot grant vector is the decoder function.
- The data path is an N:1 mux followed by a single output register.

It sits where several producers share one downstream consumer, such as bus funnels or debug/trace collectors.

## Interface
Parameters:
- NUM_CH, 4, number of input channels (≥2).
- DATA_W, 8, data width per channel.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  NUM_CH  per-channel request.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept; at most one bit set.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered data.
- out_sel  output  $clog2(NUM_CH)  binary index of the source channel of the current beat.
- out_ready  input  1  downstream accept.
- grant  output  NUM_CH  one-hot combinational grant (all zero when no request).

## Operation
- Transfer on a channel: in_valid[i] & in_ready[i] at a rising edge.
- Output transfer: out_valid & out_ready at a rising edge.
- load_en = ~out_valid | out_ready. The register accepts a new beat when it is empty or being drained in the same cycle.
- in_ready[i] = grant[i] & load_en. This path is combinational, with no dependency of in_valid on in_ready.
- Round-robin mode (MODE 0):
  - Search for the lowest requesting index starting at ptr, wrapping modulo NUM_CH.
  - On each input transfer from channel g, ptr <= (g+1) mod NUM_CH. Wrap-around: g = NUM_CH-1 gives ptr = 0.
  - ptr is unchanged when no transfer occurs. Grant may therefore move while stalled if requests change.
- Fixed-priority mode (MODE 1): grant goes to the lowest requesting index; ptr is unused and held at 0.
- On an input transfer: out_data <= selected in_data, out_sel <= g, out_valid <= 1.
- On an output transfer with no simultaneous input transfer: out_valid <= 0. out_data and out_sel hold their values.
- Simultaneous output and input transfer: the register is refilled in the same edge, out_valid stays 1, and throughput is 1 beat/cycle.
- Stall (out_valid=1, out_ready=0): all in_ready are 0, and out_data/out_sel are stable.
- A requester may drop in_valid before it is granted; no grant is latched.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready reads all zero while rst_n is low.
  - grant is combinational and reflects in_valid even in reset.
- Release of rst_n is synchronised externally. The first transfer is possible on the first rising edge after release.
- Latency: 1 cycle from input transfer to out_valid/out_data.
- Sustained throughput: 1 beat/cycle with out_ready held at 1.
- Reset mid-operation: any beat in flight in the register is discarded and ptr returns to 0.

## Structure
- Package mux_arb_pkg holds:
  - The arb_mode_e enum (ARB_RR = 0, ARB_FIXED = 1).
  - A localparam helper for the index width ($clog2 with NUM_CH≥2).
- Sub-module rr_grant (parameter NUM_CH, MODE) is the purely combinational search:
  - Inputs: req and ptr.
  - Outputs: one-hot grant, binary index, any.
  - Implemented as a double-width rotate-and-mask priority search.
- The top level contains ptr, the output register, the handshake logic and the data mux (AND-OR of one-hot grant with in_data).

## Test plan
- Reset/idle: assert rst_n=0 mid-beat with out_valid=1 → out_valid=0, out_data=0, out_sel=0 immediately. After release, with NUM_CH=4, in_valid=4'b0100 → first grant=4'b0100.
- Round-robin fairness: NUM_CH=4, all in_valid=1, in_data[i]=8'hA0+i, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3 and out_data A0..A3 repeating, one beat per cycle.
- Wrap-around/skip: ptr=3 after a grant to ch2, in_valid=4'b0011 → grant to ch0, then ch1. Then in_valid=4'b1000 → ch3, ptr wraps to 0.
- Back-pressure: out_ready=0 with a beat held (out_sel=1, out_data=8'h55) for 5 cycles under new requests → in_ready=0, output stable. Raising out_ready → drain and refill in the same edge, out_valid stays 1.
- Fixed priority: MODE=1, in_valid=4'b1010 continuously → ch1 is always granted and ch3 is starved. Dropping ch1 → ch3 is granted the next edge.
- Width sweep: NUM_CH=2, DATA_W=1 (the 2:1 mux case) and NUM_CH=8, DATA_W=32 with random valid/ready → scoreboard shows every accepted beat appears exactly once, in order, with the correct out_sel.
